// File: rtl/seven_seg_pkg.sv
// Shared definitions for the BCD counter / 7-segment display slice:
// cathode patterns (a..g, active-low), the BCD digit type and the decoder.
package seven_seg_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Cathode patterns, index 0 = segment a ... index 6 = segment g, 0 = lit
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;

    // Non-BCD codes (10..15) show nothing rather than a garbage glyph
    function automatic logic [0:6] bcd_to_seg(input bcd_digit_t d);
        logic [0:6] v_seg;
        case (d)
            4'd0:    v_seg = SEG_0;
            4'd1:    v_seg = SEG_1;
            4'd2:    v_seg = SEG_2;
            4'd3:    v_seg = SEG_3;
            4'd4:    v_seg = SEG_4;
            4'd5:    v_seg = SEG_5;
            4'd6:    v_seg = SEG_6;
            4'd7:    v_seg = SEG_7;
            4'd8:    v_seg = SEG_8;
            4'd9:    v_seg = SEG_9;
            default: v_seg = SEG_BLANK;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit of the up/down counter. A digit steps only when its
// carry_in is high; carry_out ripples combinationally to the next digit so
// the whole counter settles within one cycle. Load has priority over a step.
module bcd_digit_updown
    import seven_seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  bcd_digit_t i_load_value,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_carry_in,
    output logic       o_carry_out,
    output bcd_digit_t o_digit
);

    bcd_digit_t r_digit;

    // Carry on 9->0 when counting up, borrow on 0->9 when counting down
    assign o_carry_out = i_carry_in &
                         ((i_inc & (r_digit == 4'd9)) | (i_dec & (r_digit == 4'd0)));
    assign o_digit     = r_digit;

    // Digit register: load (non-BCD nibbles become 0), else step on carry_in
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= (i_load_value > 4'd9) ? 4'd0 : i_load_value;
        end else if (i_carry_in && i_inc) begin
            r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        end else if (i_carry_in && i_dec) begin
            r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/seven_seg_bcd_counter_mux.sv
// N-digit BCD up/down counter with prescaled count rate, parallel load,
// full-scale wrap pulse and a time-multiplexed common-anode display scan.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (digit 0 is always shown).
module seven_seg_bcd_counter_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 100000000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [0:6]              seg,
    output logic                    dp
);

    localparam int PW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

    logic [PW-1:0]         r_presc;
    logic [RW-1:0]         r_refresh;
    logic [IW-1:0]         r_idx;
    logic                  r_wrap;
    logic [NUM_DIGITS-1:0] r_an;
    logic [0:6]            r_seg;

    logic                  w_tick;
    logic                  w_refresh_tc;
    logic [NUM_DIGITS:0]   w_carry;
    bcd_digit_t            w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [0:6]            w_seg_next;

    assign w_tick       = en && (r_presc == PW'(TICK_DIV - 1));
    assign w_refresh_tc = (r_refresh == RW'(REFRESH_DIV - 1));

    // Prescaler: free-runs while enabled, frozen when not, restarts on load
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    // Digit chain: the tick enters digit 0 and ripples up as carry/borrow
    assign w_carry[0] = w_tick;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit_updown u_digit (
            .clk          (clk),
            .reset        (reset),
            .i_load       (load),
            .i_load_value (load_value[4*k +: 4]),
            .i_inc        (up_down),
            .i_dec        (~up_down),
            .i_carry_in   (w_carry[k]),
            .o_carry_out  (w_carry[k+1]),
            .o_digit      (w_digit[k])
        );
        assign count_bcd[4*k +: 4] = w_digit[k];
    end

    // Wrap pulse: carry/borrow out of the top digit on a tick that load did not override
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[NUM_DIGITS] && !load;
        end
    end

    // Refresh counter and scan index: run continuously, independent of en
    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else begin
            r_refresh <= w_refresh_tc ? '0 : r_refresh + RW'(1);
            if (w_refresh_tc) begin
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lead_zero;

    // w_lead_zero[k]: digit k and every digit above it are zero
    always_comb begin
        logic v_run;
        v_run       = 1'b1;
        w_lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_run          = v_run && (w_digit[k] == 4'd0);
            w_lead_zero[k] = v_run;
        end
    end
`endif

    // Next anode/cathode pattern for the digit currently selected by the scan
    always_comb begin
        bcd_digit_t v_cur;
        logic       v_blank;
        w_an_next = '1;
        v_cur     = 4'd0;
        v_blank   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_an_next[k] = 1'b0;
                v_cur        = w_digit[k];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
                v_blank      = (k != 0) && w_lead_zero[k];
`endif
            end
        end
        w_seg_next = v_blank ? SEG_BLANK : bcd_to_seg(v_cur);
    end

    // Registered display outputs: all segments and anodes off during reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign wrap = r_wrap;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_seven_seg_bcd_counter_mux.sv
// Directed bench for seven_seg_bcd_counter_mux (NUM_DIGITS=4, TICK_DIV=4,
// REFRESH_DIV=2). Stimulus pushes hand-computed expectations stamped with
// the clock edge they refer to; a monitor pops and compares on negedge.
module tb_seven_seg_bcd_counter_mux;

    localparam int ND = 4;

    logic          clk;
    logic          reset;
    logic          en;
    logic          up_down;
    logic          load;
    logic [15:0]   load_value;
    logic [15:0]   count_bcd;
    logic          wrap;
    logic [3:0]    an;
    logic [0:6]    seg;
    logic          dp;

    typedef struct {
        int          stamp;
        string       name;
        logic        chk_cnt;
        logic [15:0] cnt;
        logic        chk_wrap;
        logic        wrp;
        logic        chk_disp;
        logic [3:0]  an_e;
        logic [6:0]  seg_e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   rel = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0     = 7'b0000001;
    localparam logic [6:0] S_5     = 7'b0100100;

    seven_seg_bcd_counter_mux #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (4),
        .REFRESH_DIV (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count_bcd  (count_bcd),
        .wrap       (wrap),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_full(input string name, input int stamp,
                            input logic cc, input logic [15:0] c,
                            input logic cw, input logic w,
                            input logic cd, input logic [3:0] a, input logic [6:0] s);
        exp_t e;
        e.stamp = stamp; e.name = name;
        e.chk_cnt = cc;  e.cnt = c;
        e.chk_wrap = cw; e.wrp = w;
        e.chk_disp = cd; e.an_e = a; e.seg_e = s;
        exp_q.push_back(e);
    endtask

    task automatic exp_cnt(input string name, input logic [15:0] c, input logic w);
        exp_full(name, cyc, 1'b1, c, 1'b1, w, 1'b0, 4'h0, 7'h0);
    endtask

    task automatic exp_disp(input string name, input int stamp,
                            input logic [3:0] a, input logic [6:0] s);
        exp_full(name, stamp, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, a, s);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_cnt)  cmp({mon_e.name, ".count"}, 32'(count_bcd), 32'(mon_e.cnt));
            if (mon_e.chk_wrap) cmp({mon_e.name, ".wrap"},  32'(wrap),      32'(mon_e.wrp));
            if (mon_e.chk_disp) begin
                cmp({mon_e.name, ".an"},  32'(an),  32'(mon_e.an_e));
                cmp({mon_e.name, ".seg"}, 32'(seg), 32'(mon_e.seg_e));
                cmp({mon_e.name, ".dp"},  32'(dp),  32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        reset = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0; load_value = 16'h0;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step(1);
            exp_full("reset", cyc, 1'b1, 16'h0, 1'b1, 1'b0, 1'b1, 4'b1111, S_BLANK);
        end
        reset = 1'b0;
        rel   = cyc;

        // Scan sequence after reset (count 0, en=0): slot changes every 2 edges
        step(1); exp_full("scan0", cyc, 1'b1, 16'h0, 1'b1, 1'b0, 1'b1, 4'b1110, S_0);
        step(2); exp_disp("scan1", cyc, 4'b1101, S_0);
        step(2); exp_disp("scan2", cyc, 4'b1011, S_0);
        step(2); exp_disp("scan3", cyc, 4'b0111, S_0);
        step(2); exp_disp("scan4", cyc, 4'b1110, S_0);

        // Count up from 0: first tick on 4th edge, 40 edges -> 10
        en = 1'b1; up_down = 1'b1;
        step(3);  exp_cnt("up_pre_tick", 16'h0000, 1'b0);
        step(1);  exp_cnt("up_first_tick", 16'h0001, 1'b0);
        step(36); exp_cnt("up_40", 16'h0010, 1'b0);
        en = 1'b0;

        // Up wrap 9999 -> 0000
        load = 1'b1; load_value = 16'h9999; up_down = 1'b1;
        step(1); load = 1'b0; en = 1'b1;
        exp_cnt("load_9999", 16'h9999, 1'b0);
        step(3); exp_cnt("up_wrap_pre", 16'h9999, 1'b0);
        step(1); exp_cnt("up_wrap", 16'h0000, 1'b1);
        en = 1'b0;
        step(1); exp_cnt("up_wrap_end", 16'h0000, 1'b0);

        // Down wrap 0000 -> 9999, then hold with en=0
        load = 1'b1; load_value = 16'h0000; up_down = 1'b0;
        step(1); load = 1'b0; en = 1'b1;
        exp_cnt("load_0000", 16'h0000, 1'b0);
        step(4); exp_cnt("dn_wrap", 16'h9999, 1'b1);
        en = 1'b0;
        step(1);  exp_cnt("dn_wrap_end", 16'h9999, 1'b0);
        step(19); exp_cnt("en_hold", 16'h9999, 1'b0);

        // Load coinciding with tick, non-BCD nibble loads as 0
        en = 1'b1; up_down = 1'b1;
        step(3);
        load = 1'b1; load_value = 16'h12A4;
        step(1); exp_cnt("load_tick", 16'h1204, 1'b0);
        load = 1'b0; en = 1'b0;
        step(1); exp_cnt("load_tick_hold", 16'h1204, 1'b0);

        // Ripple borrow across three digits
        load = 1'b1; load_value = 16'h1000; up_down = 1'b0;
        step(1); load = 1'b0; en = 1'b1;
        step(4); exp_cnt("borrow_ripple", 16'h0999, 1'b0);
        en = 1'b0;

        // Display of 0050 across all four slots
        load = 1'b1; load_value = 16'h0050;
        step(1); load = 1'b0;
        step(1);
        guard = 0;
        while (((cyc - rel) % 8) != 1 && guard < 16) begin
            step(1);
            guard++;
        end
        exp_disp("lz_slot0", cyc,     4'b1110, S_0);
        exp_disp("lz_slot1", cyc + 2, 4'b1101, S_5);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        exp_disp("lz_slot2", cyc + 4, 4'b1011, S_BLANK);
        exp_disp("lz_slot3", cyc + 6, 4'b0111, S_BLANK);
`else
        exp_disp("lz_slot2", cyc + 4, 4'b1011, S_0);
        exp_disp("lz_slot3", cyc + 6, 4'b0111, S_0);
`endif
        step(6);

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            step(1);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
